// File: rtl/axis_loopback_sequencer.sv
// AXI-Stream loopback sequencer: emits a NUM_BEATS incrementing packet on the master
// port, then drains it from the slave port and checks every beat against the pattern.
module axis_loopback_sequencer #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_BEATS      = 16,
  parameter logic [DATA_WIDTH-1:0] SEED           = '0,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    ERR_WIDTH      = 8
) (
  input  logic                  init_clk,
  input  logic                  s_axis_aresetn,
  input  logic                  start_write,
  input  logic                  start_read,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam int                   CW       = $clog2(NUM_BEATS + 1);
  localparam int                   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]        LAST_IDX = CW'(NUM_BEATS - 1);
  localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_RD, READ, DONE} state_t;

  state_t                state;
  logic                  start_write_q;
  logic                  start_read_q;
  logic                  armed;
  logic                  write_rise;
  logic                  read_rise;
  logic [CW-1:0]         beat_cnt;
  logic [TW-1:0]         idle_cnt;
  logic                  rd_accept;
  logic                  rd_last_expected;
  logic [DATA_WIDTH-1:0] rd_expected;
  logic [1:0]            err_inc;
  logic [ERR_WIDTH:0]    err_sum;
  logic [ERR_WIDTH-1:0]  err_next;

  // armed stays low for the first cycle out of reset so a start level held through reset is not an edge
  assign write_rise = armed & start_write & ~start_write_q;
  assign read_rise  = armed & start_read & ~start_read_q;

  assign busy = (state == WRITE) || (state == READ);
  assign pass = rd_done & (err_count == '0) & ~timeout;

  always_comb begin
    rd_accept        = s_axis_tvalid & s_axis_tready;
    rd_expected      = SEED + DATA_WIDTH'(beat_cnt);
    rd_last_expected = (beat_cnt == LAST_IDX);
    err_inc          = 2'(s_axis_tdata != rd_expected) + 2'(s_axis_tlast != rd_last_expected);
    err_sum          = {1'b0, err_count} + (ERR_WIDTH + 1)'(err_inc);
    err_next         = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_WIDTH-1:0];
  end

  always_ff @(posedge init_clk) begin
    if (!s_axis_aresetn) begin
      state         <= IDLE;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      armed         <= 1'b0;
      beat_cnt      <= '0;
      idle_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
    end else begin
      armed         <= 1'b1;
      start_write_q <= start_write;
      start_read_q  <= start_read;
      if (write_rise && (state == IDLE || state == WAIT_RD || state == DONE)) begin
        state         <= WRITE;
        beat_cnt      <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        wr_done       <= 1'b0;
        rd_done       <= 1'b0;
        timeout       <= 1'b0;
        err_count     <= '0;
      end else begin
        case (state)
          IDLE, DONE: ;
          WAIT_RD: begin
            if (read_rise) begin
              state         <= READ;
              s_axis_tready <= 1'b1;
              beat_cnt      <= '0;
              idle_cnt      <= '0;
            end
          end
          WRITE: begin
            // beat_cnt indexes the beat currently presented on the master port
            if (!m_axis_tvalid) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= SEED + DATA_WIDTH'(beat_cnt);
              m_axis_tlast  <= (beat_cnt == LAST_IDX);
            end else if (m_axis_tready) begin
              if (m_axis_tlast) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                wr_done       <= 1'b1;
                state         <= WAIT_RD;
              end else begin
                beat_cnt     <= beat_cnt + 1'b1;
                m_axis_tdata <= m_axis_tdata + 1'b1;
                m_axis_tlast <= ((beat_cnt + 1'b1) == LAST_IDX);
              end
            end
          end
          READ: begin
            if (rd_accept) begin
              err_count <= err_next;
              beat_cnt  <= beat_cnt + 1'b1;
              idle_cnt  <= '0;
              if (s_axis_tlast || rd_last_expected) begin
                state         <= DONE;
                s_axis_tready <= 1'b0;
                rd_done       <= 1'b1;
              end
            end else if (idle_cnt == TO_LAST) begin
              state         <= DONE;
              s_axis_tready <= 1'b0;
              rd_done       <= 1'b1;
              timeout       <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_loopback_sequencer.sv
// Bench for axis_loopback_sequencer: per-cycle comparison against a phase-level model,
// plus directed loopback scenarios and randomized rounds.
module tb_axis_loopback_sequencer;

  localparam int          NB     = 16;
  localparam int          TO     = 256;
  localparam logic [31:0] SEED_A = 32'd0;
  localparam logic [31:0] SEED_B = 32'hFFFF_FFFD;

  localparam int P_IDLE  = 0;
  localparam int P_WRITE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_READ  = 3;
  localparam int P_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic        m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;

  logic [31:0] a_tdata;
  logic        a_tvalid, a_tlast, a_s_tready, a_busy, a_wr_done, a_rd_done, a_pass, a_timeout;
  logic [7:0]  a_err;
  logic [31:0] b_tdata;
  logic        b_tvalid, b_tlast, b_s_tready, b_busy, b_wr_done, b_rd_done, b_pass, b_timeout;
  logic [7:0]  b_err;

  int tests_run = 0;
  int tests_failed = 0;

  axis_loopback_sequencer #(.DATA_WIDTH(32), .NUM_BEATS(NB), .SEED(SEED_A),
                            .TIMEOUT_CYCLES(TO), .ERR_WIDTH(8)) dut_a (
    .init_clk(clk), .s_axis_aresetn(rst_n), .start_write(start_write), .start_read(start_read),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(a_tlast), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(s_tlast), .busy(a_busy), .wr_done(a_wr_done),
    .rd_done(a_rd_done), .pass(a_pass), .timeout(a_timeout), .err_count(a_err));

  // Second instance only exercises the wrapping seed on the write side
  axis_loopback_sequencer #(.DATA_WIDTH(32), .NUM_BEATS(NB), .SEED(SEED_B),
                            .TIMEOUT_CYCLES(TO), .ERR_WIDTH(8)) dut_b (
    .init_clk(clk), .s_axis_aresetn(rst_n), .start_write(start_write), .start_read(start_read),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(b_tlast), .s_axis_tdata(32'd0), .s_axis_tvalid(1'b0),
    .s_axis_tready(b_s_tready), .s_axis_tlast(1'b0), .busy(b_busy), .wr_done(b_wr_done),
    .rd_done(b_rd_done), .pass(b_pass), .timeout(b_timeout), .err_count(b_err));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Model state: which phase the sequencer should be in and its observable counters
  int   md_phase = P_IDLE;
  int   md_idx = 0;
  int   md_rx = 0;
  int   md_idle = 0;
  int   md_err = 0;
  bit   md_tvalid = 0, md_wr_done = 0, md_rd_done = 0, md_timeout = 0;
  bit   md_prev_sw = 0, md_prev_sr = 0, md_armed = 0;
  bit   model_ready = 0;
  bit   rise_w, rise_r;

  logic [31:0] loop_data[$];
  bit          loop_last[$];
  logic [31:0] wrap_data[$];
  int          hs_count = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("m_tvalid", 64'(a_tvalid), 64'(md_tvalid));
      if (md_tvalid) begin
        checkOutput("m_tdata", 64'(a_tdata), 64'(32'(SEED_A + 32'(md_idx))));
        checkOutput("m_tlast", 64'(a_tlast), 64'(md_idx == NB - 1));
      end
      checkOutput("s_tready", 64'(a_s_tready), 64'(md_phase == P_READ));
      checkOutput("busy", 64'(a_busy), 64'(md_phase == P_WRITE || md_phase == P_READ));
      checkOutput("wr_done", 64'(a_wr_done), 64'(md_wr_done));
      checkOutput("rd_done", 64'(a_rd_done), 64'(md_rd_done));
      checkOutput("timeout", 64'(a_timeout), 64'(md_timeout));
      checkOutput("err_count", 64'(a_err), 64'(md_err));
      checkOutput("pass", 64'(a_pass), 64'(md_rd_done && md_err == 0 && !md_timeout));
      if (prev_hold)
        checkOutput("hold_stable", {31'd0, a_tvalid, a_tlast, a_tdata}, {31'd0, 1'b1, prev_last, prev_data});
    end
    prev_hold = rst_n && a_tvalid && !m_tready;
    prev_data = a_tdata;
    prev_last = a_tlast;
    if (rst_n && a_tvalid && m_tready) begin
      loop_data.push_back(a_tdata);
      loop_last.push_back(a_tlast);
      hs_count++;
    end
    if (rst_n && b_tvalid && m_tready) wrap_data.push_back(b_tdata);

    // Predict the effect of the coming rising edge from the inputs it will sample
    if (!rst_n) begin
      md_phase = P_IDLE; md_idx = 0; md_rx = 0; md_idle = 0; md_err = 0;
      md_tvalid = 0; md_wr_done = 0; md_rd_done = 0; md_timeout = 0;
      md_prev_sw = 0; md_prev_sr = 0; md_armed = 0;
      model_ready = 1;
    end else if (model_ready) begin
      rise_w = md_armed && start_write && !md_prev_sw;
      rise_r = md_armed && start_read && !md_prev_sr;
      md_armed = 1; md_prev_sw = start_write; md_prev_sr = start_read;
      if (rise_w && (md_phase == P_IDLE || md_phase == P_WAIT || md_phase == P_DONE)) begin
        md_phase = P_WRITE; md_idx = 0; md_tvalid = 0; md_err = 0;
        md_wr_done = 0; md_rd_done = 0; md_timeout = 0;
      end else if (md_phase == P_WAIT && rise_r) begin
        md_phase = P_READ; md_rx = 0; md_idle = 0;
      end else if (md_phase == P_WRITE) begin
        if (!md_tvalid) md_tvalid = 1;
        else if (m_tready) begin
          if (md_idx == NB - 1) begin
            md_tvalid = 0; md_wr_done = 1; md_phase = P_WAIT;
          end else md_idx++;
        end
      end else if (md_phase == P_READ) begin
        if (s_tvalid) begin
          md_err = md_err + int'(s_tdata != 32'(SEED_A + 32'(md_rx))) + int'(s_tlast != (md_rx == NB - 1));
          if (md_err > 255) md_err = 255;
          md_rx++; md_idle = 0;
          if (s_tlast || md_rx == NB) begin md_phase = P_DONE; md_rd_done = 1; end
        end else begin
          md_idle++;
          if (md_idle == TO) begin md_phase = P_DONE; md_rd_done = 1; md_timeout = 1; end
        end
      end
    end
  end

  // mode 0: tready always high, 1: toggling, 2: random
  task automatic applyStimulus(input int mode, output int cycles);
    loop_data.delete(); loop_last.delete(); wrap_data.delete(); hs_count = 0;
    @(posedge clk); #1; start_write = 1'b1; m_tready = (mode == 0);
    @(posedge clk); #1; start_write = 1'b0;
    cycles = 0;
    while (!a_wr_done && cycles < 400) begin
      if (mode == 1) m_tready = ~m_tready;
      else if (mode == 2) m_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; cycles++;
    end
    checkOutput("write_completes", 64'(a_wr_done), 64'd1);
  endtask

  // vmode 0: valid whenever data is queued, 1: random gaps, 2: never valid
  task automatic runRead(input int corrupt_idx, input int early_idx, input int vmode,
                         output int accepted, output int cycles);
    bit acc_now;
    int k;
    k = 0;
    @(posedge clk); #1; start_read = 1'b1; s_tvalid = 1'b0;
    @(posedge clk); #1; start_read = 1'b0;
    cycles = 0;
    while (!a_rd_done && cycles < 600) begin
      if (vmode != 2 && loop_data.size() > 0 && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = loop_data[0] ^ ((k == corrupt_idx) ? 32'h10 : 32'h0);
        s_tlast  = loop_last[0] | (k == early_idx);
      end else begin
        s_tvalid = 1'b0;
      end
      @(negedge clk);
      acc_now = s_tvalid && a_s_tready;
      @(posedge clk); #1; cycles++;
      if (acc_now) begin
        void'(loop_data.pop_front()); void'(loop_last.pop_front()); k++;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    accepted = k;
    checkOutput("read_completes", 64'(a_rd_done), 64'd1);
  endtask

  initial begin
    int cyc, acc;
    // Reset with start_write held high: no write may launch when reset releases
    start_write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", 64'(a_tvalid), 64'd0);
    checkOutput("reset_busy", 64'(a_busy), 64'd0);
    checkOutput("reset_err", 64'(a_err), 64'd0);
    checkOutput("reset_tready", 64'(a_s_tready), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("held_start_no_edge", 64'(a_busy), 64'd0);
    start_write = 1'b0;
    repeat (2) @(posedge clk);

    // Full-rate write, then ideal loopback read
    applyStimulus(0, cyc);
    checkOutput("t1_cycles", 64'(cyc), 64'd17);
    checkOutput("t1_handshakes", 64'(hs_count), 64'd16);
    for (int i = 0; i < NB; i++) checkOutput("t1_data", 64'(loop_data[i]), 64'(i));
    checkOutput("t1_last15", 64'(loop_last[15]), 64'd1);
    checkOutput("t1_last14", 64'(loop_last[14]), 64'd0);
    checkOutput("wrap_beat0", 64'(wrap_data[0]), 64'hFFFF_FFFD);
    checkOutput("wrap_beat3", 64'(wrap_data[3]), 64'd0);
    checkOutput("wrap_beat15", 64'(wrap_data[15]), 64'd12);
    runRead(-1, -1, 0, acc, cyc);
    checkOutput("t2_accepted", 64'(acc), 64'd16);
    checkOutput("t2_cycles", 64'(cyc), 64'd16);
    checkOutput("t2_err", 64'(a_err), 64'd0);
    checkOutput("t2_pass", 64'(a_pass), 64'd1);

    // Toggling downstream ready
    applyStimulus(1, cyc);
    checkOutput("t3_handshakes", 64'(hs_count), 64'd16);
    for (int i = 0; i < NB; i++) checkOutput("t3_data", 64'(loop_data[i]), 64'(i));
    runRead(-1, -1, 1, acc, cyc);
    checkOutput("t3_pass", 64'(a_pass), 64'd1);

    // Corrupt beat 5, early tlast on beat 10
    applyStimulus(0, cyc);
    runRead(5, 10, 0, acc, cyc);
    checkOutput("t4_accepted", 64'(acc), 64'd11);
    checkOutput("t4_err", 64'(a_err), 64'd2);
    checkOutput("t4_pass", 64'(a_pass), 64'd0);
    checkOutput("t4_timeout", 64'(a_timeout), 64'd0);

    // Empty FIFO: timeout
    applyStimulus(0, cyc);
    runRead(-1, -1, 2, acc, cyc);
    checkOutput("t5_cycles", 64'(cyc), 64'd256);
    checkOutput("t5_timeout", 64'(a_timeout), 64'd1);
    checkOutput("t5_pass", 64'(a_pass), 64'd0);

    // Reset during write beat 7
    hs_count = 0; m_tready = 1'b1;
    @(posedge clk); #1; start_write = 1'b1;
    @(posedge clk); #1; start_write = 1'b0;
    for (int c = 0; c < 100 && hs_count < 7; c++) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("t6_hs_before_reset", 64'(hs_count), 64'd7);
    checkOutput("t6_reset_tvalid", 64'(a_tvalid), 64'd0);
    checkOutput("t6_reset_busy", 64'(a_busy), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Simultaneous write and read rises in WAIT_RD
    applyStimulus(0, cyc);
    @(posedge clk); #1; start_write = 1'b1; start_read = 1'b1;
    @(posedge clk); #1; start_write = 1'b0; start_read = 1'b0;
    checkOutput("t6_both_busy", 64'(a_busy), 64'd1);
    checkOutput("t6_both_wr_done", 64'(a_wr_done), 64'd0);
    checkOutput("t6_both_s_tready", 64'(a_s_tready), 64'd0);
    for (int c = 0; c < 100 && !a_wr_done; c++) @(posedge clk);
    #1;

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      applyStimulus(2, cyc);
      runRead($urandom_range(0, 3) == 0 ? int'($urandom_range(0, NB - 1)) : -1,
              $urandom_range(0, 3) == 0 ? int'($urandom_range(0, NB - 1)) : -1, 1, acc, cyc);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
